// File: rtl/rtl_inf_pkg.sv
// Shared types and default sizing for the rtl_inf inference datapath.
// The accumulator-width helper keeps the lane and the top in agreement.
package rtl_inf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_GROUP_SIZE             = 4;
  localparam int DEF_DATA_WIDTH             = 8;
  localparam int DEF_NUM_INPUTS             = 9;
  localparam int DEF_NUM_LANES              = 9;
  localparam int DEF_NUM_OUTPUTS            = 9;
  localparam int DEF_LOG_MAX_ITERS          = 8;
  localparam int DEF_LOG_MAX_READS_PER_ITER = 8;
  localparam int DEF_NUM_ADDRESSES          = 4096;
  localparam int DEF_LOG_MAX_ADDRESS        = $clog2(DEF_NUM_ADDRESSES);

  // A full iteration of max-size products must fit without overflow.
  function automatic int acc_width(input int data_width, input int log_max_reads);
    return 2 * data_width + log_max_reads;
  endfunction

endpackage

// File: rtl/rtl_inf_lane.sv
// One MAC lane: GROUP_SIZE unsigned multipliers sharing one weight byte.
// acc_next exposes the post-beat value so the top can register results on the final beat.
module rtl_inf_lane
  import rtl_inf_pkg::*;
#(
  parameter int GROUP_SIZE = DEF_GROUP_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = acc_width(DEF_DATA_WIDTH, DEF_LOG_MAX_READS_PER_ITER)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             load,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] act,
  input  logic [DATA_WIDTH-1:0]            weight,
  output logic [GROUP_SIZE*ACC_WIDTH-1:0]  acc_next
);

  logic [GROUP_SIZE*ACC_WIDTH-1:0] acc;

  // NOTE: the output is given a full default before the loop, so no latch can be inferred.
  always_comb begin
    acc_next = '0;
    for (int e = 0; e < GROUP_SIZE; e++) begin
      acc_next[e*ACC_WIDTH +: ACC_WIDTH] =
        (load ? ACC_WIDTH'(0) : acc[e*ACC_WIDTH +: ACC_WIDTH]) +
        ACC_WIDTH'(act[e*DATA_WIDTH +: DATA_WIDTH]) * ACC_WIDTH'(weight);
    end
  end

  // NOTE: accumulators are plain flops (not a RAM), so they can and do take the async reset.
  // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/rtl_inf.sv
// Inference datapath top: run FSM, read strobes, lane routing, lane combine,
// clipping and registered output writes.
module rtl_inf
  import rtl_inf_pkg::*;
#(
  parameter int GROUP_SIZE             = DEF_GROUP_SIZE,
  parameter int DATA_WIDTH             = DEF_DATA_WIDTH,
  parameter int NUM_INPUTS             = DEF_NUM_INPUTS,
  parameter int NUM_LANES              = DEF_NUM_LANES,
  parameter int NUM_OUTPUTS            = DEF_NUM_OUTPUTS,
  parameter int LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
  parameter int LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER,
  parameter int LOG_MAX_ADDRESS        = DEF_LOG_MAX_ADDRESS
) (
  input  logic                                        clk,
  input  logic                                        rst,
  output logic [NUM_INPUTS-1:0]                       act_read,
  output logic [NUM_INPUTS*LOG_MAX_ADDRESS-1:0]       act_addr,
  input  logic [NUM_INPUTS*GROUP_SIZE*DATA_WIDTH-1:0] act_data,
  input  logic [NUM_INPUTS-1:0]                       act_valid,
  output logic                                        weight_read,
  output logic [LOG_MAX_ADDRESS-1:0]                  weight_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]             weight_data,
  input  logic                                        weight_valid,
  input  logic                                        configure,
  input  logic [LOG_MAX_ITERS-1:0]                    num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0]           num_reads_per_iter,
  input  logic [LOG_MAX_ADDRESS-1:0]                  read_address,
  input  logic [LOG_MAX_ADDRESS-1:0]                  write_address,
  input  logic [DATA_WIDTH-1:0]                       min_clip,
  input  logic [DATA_WIDTH-1:0]                       max_clip,
  input  logic                                        conf_mode_in,
  input  logic                                        conf_mode_out,
  output logic [NUM_OUTPUTS*GROUP_SIZE*DATA_WIDTH-1:0] data_out,
  output logic [NUM_OUTPUTS*LOG_MAX_ADDRESS-1:0]      addr_out,
  output logic [NUM_OUTPUTS-1:0]                      valid_out
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, LOG_MAX_READS_PER_ITER);
  localparam int SUM_WIDTH = ACC_WIDTH + $clog2(NUM_LANES);
  localparam int GW        = GROUP_SIZE * DATA_WIDTH;

  state_t state, state_next;

  logic [LOG_MAX_ITERS-1:0]          cfg_last_iter;
  logic [LOG_MAX_READS_PER_ITER-1:0] cfg_last_read;
  logic [LOG_MAX_ADDRESS-1:0]        cfg_raddr, cfg_waddr;
  logic [DATA_WIDTH-1:0]             cfg_min, cfg_max;
  logic                              cfg_mode_in, cfg_mode_out;

  logic [LOG_MAX_ITERS-1:0]          iter_cnt, out_iter;
  logic [LOG_MAX_READS_PER_ITER-1:0] read_cnt, beat_cnt;
  logic [LOG_MAX_ADDRESS-1:0]        rd_addr, wt_addr, wr_addr;
  logic                              start, last_beat, beat_ok, iter_done, lane_load;

  logic [GW-1:0]                   lane_act [NUM_LANES];
  logic [GROUP_SIZE*ACC_WIDTH-1:0] lane_acc [NUM_LANES];
  logic [SUM_WIDTH-1:0]            elem_sum [GROUP_SIZE];
  logic [NUM_OUTPUTS*GW-1:0]       data_next;

  // Lower bound first, then upper: an inverted window therefore resolves to max_clip.
  function automatic logic [DATA_WIDTH-1:0] clip(input logic [SUM_WIDTH-1:0] v,
                                                 input logic [DATA_WIDTH-1:0] lo,
                                                 input logic [DATA_WIDTH-1:0] hi);
    logic [SUM_WIDTH-1:0] t;
    t = (v < SUM_WIDTH'(lo)) ? SUM_WIDTH'(lo) : v;
    if (t > SUM_WIDTH'(hi)) t = SUM_WIDTH'(hi);
    return t[DATA_WIDTH-1:0];
  endfunction

  assign start     = (state == IDLE) && configure && (num_iters != '0) && (num_reads_per_iter != '0);
  assign last_beat = (iter_cnt == cfg_last_iter) && (read_cnt == cfg_last_read);
  assign beat_ok   = weight_valid && (&act_valid);
  assign lane_load = (beat_cnt == '0);
  assign iter_done = beat_ok && (beat_cnt == cfg_last_read);
  assign rd_addr   = cfg_raddr + LOG_MAX_ADDRESS'(read_cnt);
  assign wt_addr   = LOG_MAX_ADDRESS'({iter_cnt, read_cnt});
  assign wr_addr   = cfg_waddr + LOG_MAX_ADDRESS'(out_iter);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_last_iter <= '0;
      cfg_last_read <= '0;
      cfg_raddr     <= '0;
      cfg_waddr     <= '0;
      cfg_min       <= '0;
      cfg_max       <= '0;
      cfg_mode_in   <= 1'b0;
      cfg_mode_out  <= 1'b0;
      iter_cnt      <= '0;
      read_cnt      <= '0;
    end else if (start) begin
      cfg_last_iter <= num_iters - LOG_MAX_ITERS'(1);
      cfg_last_read <= num_reads_per_iter - LOG_MAX_READS_PER_ITER'(1);
      cfg_raddr     <= read_address;
      cfg_waddr     <= write_address;
      cfg_min       <= min_clip;
      cfg_max       <= max_clip;
      cfg_mode_in   <= conf_mode_in;
      cfg_mode_out  <= conf_mode_out;
      iter_cnt      <= '0;
      read_cnt      <= '0;
    end else if (state == RUN) begin
      if (read_cnt == cfg_last_read) begin
        read_cnt <= '0;
        iter_cnt <= iter_cnt + LOG_MAX_ITERS'(1);
      end else begin
        read_cnt <= read_cnt + LOG_MAX_READS_PER_ITER'(1);
      end
    end
  end

  // Strobes are registered copies of the beat the FSM is sitting on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_read    <= '0;
      act_addr    <= '0;
      weight_read <= 1'b0;
      weight_addr <= '0;
    end else if (state == RUN) begin
      act_read    <= '1;
      act_addr    <= {NUM_INPUTS{rd_addr}};
      weight_read <= 1'b1;
      weight_addr <= wt_addr;
    end else begin
      act_read    <= '0;
      act_addr    <= '0;
      weight_read <= 1'b0;
      weight_addr <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      out_iter <= '0;
    end else if (start) begin
      beat_cnt <= '0;
      out_iter <= '0;
    end else if (beat_ok) begin
      if (iter_done) begin
        beat_cnt <= '0;
        out_iter <= out_iter + LOG_MAX_ITERS'(1);
      end else begin
        beat_cnt <= beat_cnt + LOG_MAX_READS_PER_ITER'(1);
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_act[l] = cfg_mode_in ? act_data[l*GW +: GW] : act_data[0 +: GW];

    rtl_inf_lane #(
      .GROUP_SIZE (GROUP_SIZE),
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (beat_ok),
      .load     (lane_load),
      .act      (lane_act[l]),
      .weight   (weight_data[l*DATA_WIDTH +: DATA_WIDTH]),
      .acc_next (lane_acc[l])
    );
  end

  // The combine works on acc_next so the final beat's product is included on the same edge.
  always_comb begin
    for (int e = 0; e < GROUP_SIZE; e++) begin
      elem_sum[e] = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        elem_sum[e] = elem_sum[e] + SUM_WIDTH'(lane_acc[l][e*ACC_WIDTH +: ACC_WIDTH]);
      end
    end
    data_next = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      for (int e = 0; e < GROUP_SIZE; e++) begin
        data_next[(o*GROUP_SIZE+e)*DATA_WIDTH +: DATA_WIDTH] =
          clip(cfg_mode_out ? SUM_WIDTH'(lane_acc[o][e*ACC_WIDTH +: ACC_WIDTH]) : elem_sum[e],
               cfg_min, cfg_max);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= '0;
      data_out  <= '0;
      addr_out  <= '0;
    end else begin
      valid_out <= iter_done ? '1 : '0;
      if (iter_done) begin
        data_out <= data_next;
        addr_out <= {NUM_OUTPUTS{wr_addr}};
      end
    end
  end

endmodule

// File: tb/tb_rtl_inf.sv
// Scoreboard bench for rtl_inf: stimulus pushes expected reads and writes,
// negedge monitors pop and compare whenever the DUT strobes or writes.
module tb_rtl_inf;
  import rtl_inf_pkg::*;

  localparam int GS = 4, DW = 8, NI = 9, NL = 9, NO = 9;
  localparam int LI = 8, LR = 8, LA = 12;
  localparam int GW = GS * DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NI-1:0]     act_read;
  logic [NI*LA-1:0]  act_addr;
  logic [NI*GW-1:0]  act_data;
  logic [NI-1:0]     act_valid;
  logic              weight_read;
  logic [LA-1:0]     weight_addr;
  logic [NL*DW-1:0]  weight_data;
  logic              weight_valid;
  logic              configure;
  logic [LI-1:0]     num_iters;
  logic [LR-1:0]     num_reads_per_iter;
  logic [LA-1:0]     read_address, write_address;
  logic [DW-1:0]     min_clip, max_clip;
  logic              conf_mode_in, conf_mode_out;
  logic [NO*GW-1:0]  data_out;
  logic [NO*LA-1:0]  addr_out;
  logic [NO-1:0]     valid_out;

  rtl_inf dut (
    .clk(clk), .rst(rst),
    .act_read(act_read), .act_addr(act_addr), .act_data(act_data), .act_valid(act_valid),
    .weight_read(weight_read), .weight_addr(weight_addr),
    .weight_data(weight_data), .weight_valid(weight_valid),
    .configure(configure), .num_iters(num_iters), .num_reads_per_iter(num_reads_per_iter),
    .read_address(read_address), .write_address(write_address),
    .min_clip(min_clip), .max_clip(max_clip),
    .conf_mode_in(conf_mode_in), .conf_mode_out(conf_mode_out),
    .data_out(data_out), .addr_out(addr_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // Memory models: constant contents per test, one-cycle read latency.
  logic [GW-1:0] act_word [NI];
  logic [DW-1:0] wt_byte  [NL];

  always_comb begin
    act_data = '0;
    weight_data = '0;
    for (int i = 0; i < NI; i++) act_data[i*GW +: GW] = act_word[i];
    for (int l = 0; l < NL; l++) weight_data[l*DW +: DW] = wt_byte[l];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_valid    <= '0;
      weight_valid <= 1'b0;
    end else begin
      act_valid    <= act_read;
      weight_valid <= weight_read;
    end
  end

  typedef struct {
    logic [NO*GW-1:0] data;
    logic [LA-1:0]    addr;
    int               gap;
    bit               last;
  } out_exp_t;

  typedef struct {
    logic [LA-1:0] raddr;
    logic [LA-1:0] waddr;
  } rd_exp_t;

  out_exp_t out_q[$];
  rd_exp_t  rd_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  int last_pulse_cyc = 0;
  int pulse_count = 0;
  int strobe_count = 0;

  task automatic check(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Read-side monitor.
  always @(negedge clk) begin
    rd_exp_t r;
    if (act_read != '0 || weight_read) begin
      strobe_count++;
      last_strobe_cyc = cyc;
      if (rd_q.size() == 0) begin
        check("unexpected_read", {act_read, weight_read}, '0);
      end else begin
        r = rd_q.pop_front();
        check("act_read", act_read, {NI{1'b1}});
        check("act_addr", act_addr, {NI{r.raddr}});
        check("weight_read", weight_read, 1'b1);
        check("weight_addr", weight_addr, r.waddr);
      end
    end
  end

  // Write-side monitor.
  always @(negedge clk) begin
    out_exp_t o;
    if (valid_out != '0) begin
      pulse_count++;
      if (out_q.size() == 0) begin
        check("unexpected_valid", valid_out, '0);
      end else begin
        o = out_q.pop_front();
        check("valid_out", valid_out, {NO{1'b1}});
        check("data_out", data_out, o.data);
        check("addr_out", addr_out, {NO{o.addr}});
        if (o.gap > 0) check("pulse_gap", cyc - last_pulse_cyc, o.gap);
        if (o.last) check("last_latency", cyc - last_strobe_cyc, 2);
      end
      last_pulse_cyc = cyc;
    end
  end

  function automatic logic [NO*GW-1:0] fill(input logic [DW-1:0] v);
    return {(NO*GS){v}};
  endfunction

  task automatic set_act_all(input logic [DW-1:0] v);
    for (int i = 0; i < NI; i++) act_word[i] = {GS{v}};
  endtask

  task automatic set_wt_all(input logic [DW-1:0] v);
    for (int l = 0; l < NL; l++) wt_byte[l] = v;
  endtask

  task automatic push_run(input int iters, input int reads, input logic [LA-1:0] raddr,
                          input logic [LA-1:0] waddr, input logic [NO*GW-1:0] data);
    rd_exp_t  r;
    out_exp_t o;
    for (int k = 0; k < iters; k++) begin
      for (int b = 0; b < reads; b++) begin
        r.raddr = raddr + LA'(b);
        r.waddr = LA'((k << LR) | b);
        rd_q.push_back(r);
      end
      o.data = data;
      o.addr = waddr + LA'(k);
      o.gap  = (k == 0) ? 0 : reads;
      o.last = (k == iters - 1);
      out_q.push_back(o);
    end
  endtask

  task automatic do_cfg(input int iters, input int reads, input int raddr, input int waddr,
                        input int lo, input int hi, input bit mi, input bit mo);
    num_iters          = LI'(iters);
    num_reads_per_iter = LR'(reads);
    read_address       = LA'(raddr);
    write_address      = LA'(waddr);
    min_clip           = DW'(lo);
    max_clip           = DW'(hi);
    conf_mode_in       = mi;
    conf_mode_out      = mo;
    configure          = 1'b1;
    @(posedge clk); #1;
    configure          = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((out_q.size() != 0 || rd_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 3000) begin
      check(name, out_q.size() + rd_q.size(), 0);
      out_q.delete();
      rd_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {act_read, act_addr, weight_read, weight_addr, valid_out, data_out, addr_out}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NO*GW-1:0] exp;
    int p0, s0;
    rst = 1'b1;
    configure = 1'b0;
    num_iters = '0;
    num_reads_per_iter = '0;
    read_address = '0;
    write_address = '0;
    min_clip = '0;
    max_clip = '0;
    conf_mode_in = 1'b0;
    conf_mode_out = 1'b0;
    set_act_all(8'd0);
    set_wt_all(8'd0);
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Per-lane mode: 4 beats x 1 x 2 = 8 per element, pulses 4 cycles apart.
    set_act_all(8'd1);
    set_wt_all(8'd2);
    push_run(2, 4, 12'd10, 12'd100, fill(8'd8));
    do_cfg(2, 4, 10, 100, 0, 255, 1'b1, 1'b1);
    wait_done("timeout_t1");

    // Broadcast + sum: port 0 = 1, weights 1 -> 16 per lane, 9 lanes -> 144.
    set_act_all(8'd7);
    act_word[0] = {GS{8'd1}};
    set_wt_all(8'd1);
    push_run(4, 16, 12'd0, 12'd200, fill(8'd144));
    do_cfg(4, 16, 0, 200, 0, 255, 1'b0, 1'b0);
    wait_done("timeout_t2");

    push_run(4, 16, 12'd0, 12'd300, fill(8'd100));
    do_cfg(4, 16, 0, 300, 0, 100, 1'b0, 1'b0);
    wait_done("timeout_t3a");

    push_run(4, 16, 12'd0, 12'd400, fill(8'd200));
    do_cfg(4, 16, 0, 400, 200, 255, 1'b0, 1'b0);
    wait_done("timeout_t3b");

    // Inverted window: max_clip wins.
    push_run(1, 16, 12'd0, 12'd500, fill(8'd100));
    do_cfg(1, 16, 0, 500, 200, 100, 1'b0, 1'b0);
    wait_done("timeout_t3c");

    // Distinct per port/lane: act(i,e)=i+e, weight l=l+1, 2 beats -> 2*(i+e)*(i+1).
    exp = '0;
    for (int i = 0; i < NI; i++) begin
      wt_byte[i] = DW'(i + 1);
      for (int e = 0; e < GS; e++) begin
        act_word[i][e*DW +: DW] = DW'(i + e);
        exp[(i*GS+e)*DW +: DW] = DW'(2 * (i + e) * (i + 1));
      end
    end
    push_run(1, 2, 12'd50, 12'd600, exp);
    do_cfg(1, 2, 50, 600, 0, 255, 1'b1, 1'b1);
    wait_done("timeout_t4a");

    // Same data, summed, 1 beat: e0 = sum l*(l+1) = 240; e1..3 exceed 250 -> 250.
    exp = {NO{8'd250, 8'd250, 8'd250, 8'd240}};
    push_run(1, 1, 12'd60, 12'd700, exp);
    do_cfg(1, 1, 60, 700, 0, 250, 1'b1, 1'b0);
    wait_done("timeout_t4b");

    // Address wrap: 4094, 4095, 0, 1.
    set_act_all(8'd1);
    set_wt_all(8'd2);
    push_run(1, 4, 12'd4094, 12'd4095, fill(8'd8));
    do_cfg(1, 4, 4094, 4095, 0, 255, 1'b1, 1'b1);
    wait_done("timeout_wrap");

    // Zero iterations or zero reads: nothing happens.
    p0 = pulse_count;
    s0 = strobe_count;
    do_cfg(0, 4, 0, 0, 0, 255, 1'b1, 1'b1);
    repeat (10) @(posedge clk); #1;
    do_cfg(2, 0, 0, 0, 0, 255, 1'b1, 1'b1);
    repeat (10) @(posedge clk); #1;
    check("zero_cfg_strobes", strobe_count - s0, 0);
    check("zero_cfg_pulses", pulse_count - p0, 0);

    // Configure while running is ignored.
    p0 = pulse_count;
    push_run(2, 4, 12'd20, 12'd800, fill(8'd8));
    do_cfg(2, 4, 20, 800, 0, 255, 1'b1, 1'b1);
    @(posedge clk); #1;
    do_cfg(1, 1, 900, 999, 0, 3, 1'b0, 1'b0);
    wait_done("timeout_busy_cfg");
    check("busy_cfg_pulses", pulse_count - p0, 2);

    // Reset mid-run aborts everything.
    push_run(4, 16, 12'd0, 12'd1000, fill(8'd144));
    set_act_all(8'd1);
    set_wt_all(8'd1);
    do_cfg(4, 16, 0, 1000, 0, 255, 1'b0, 1'b0);
    repeat (10) @(posedge clk); #1;
    rst = 1'b1;
    out_q.delete();
    rd_q.delete();
    @(negedge clk);
    check_all_zero("midrun_reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    p0 = pulse_count;
    s0 = strobe_count;
    repeat (40) @(posedge clk); #1;
    check("post_reset_pulses", pulse_count - p0, 0);
    check("post_reset_strobes", strobe_count - s0, 0);

    // Fresh run after reset.
    set_act_all(8'd1);
    set_wt_all(8'd2);
    push_run(2, 4, 12'd10, 12'd100, fill(8'd8));
    do_cfg(2, 4, 10, 100, 0, 255, 1'b1, 1'b1);
    wait_done("timeout_after_reset");

    check("rd_q_drained", rd_q.size(), 0);
    check("out_q_drained", out_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtl_inf.md
Name: rtl_inf

Overview:
- Compact inference datapath: NUM_LANES multiply-accumulate lanes between activation/weight read memories and output memories.
- On a configure pulse it issues a run of reads over iterations.
- Per read beat it routes activation groups to lanes, multiplies each group element by the lane's weight byte and accumulates.
- At each iteration end it combines lanes, clips, and emits one write per output port.

Parameters:
- GROUP_SIZE, 4, elements per activation word
- DATA_WIDTH, 8, bits per element/weight (unsigned)
- NUM_INPUTS, 9, activation read ports
- NUM_LANES, 9, MAC lanes (must equal NUM_INPUTS and NUM_OUTPUTS)
- NUM_OUTPUTS, 9, output write ports
- LOG_MAX_ITERS, 8, width of num_iters
- LOG_MAX_READS_PER_ITER, 8, width of num_reads_per_iter (equal to LOG_MAX_ITERS)
- LOG_MAX_ADDRESS, 12, address width
- NUM_ADDRESSES, 4096, memory depth (address arithmetic wraps modulo 2^LOG_MAX_ADDRESS)

Ports:
- clk in 1 clock
- rst in 1 asynchronous active-high reset
- act_read out NUM_INPUTS per-port read strobe
- act_addr out NUM_INPUTS*LOG_MAX_ADDRESS per-port read address, port i at slice i
- act_data in NUM_INPUTS*GROUP_SIZE*DATA_WIDTH per-port read data, element e at slice e
- act_valid in NUM_INPUTS read data valid
- weight_read out 1 weight read strobe
- weight_addr out LOG_MAX_ADDRESS weight read address
- weight_data in NUM_LANES*DATA_WIDTH weight bytes, lane l at slice l
- weight_valid in 1 weight data valid
- configure in 1 start pulse; latches all configuration inputs below
- num_iters in LOG_MAX_ITERS iterations
- num_reads_per_iter in LOG_MAX_READS_PER_ITER read beats per iteration
- read_address, write_address in LOG_MAX_ADDRESS base addresses
- min_clip, max_clip in DATA_WIDTH clip bounds
- conf_mode_in in 1: 0 = input 0 broadcast to all lanes; 1 = input i to lane i
- conf_mode_out in 1: 0 = element-wise sum of all lanes to every output; 1 = lane i to output i
- data_out out NUM_OUTPUTS*GROUP_SIZE*DATA_WIDTH
- addr_out out NUM_OUTPUTS*LOG_MAX_ADDRESS
- valid_out out NUM_OUTPUTS

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters and accumulators 0.
- Memories have 1-cycle read latency: data/valid appear the cycle after a read strobe.
- FSM states IDLE and RUN.
  - In IDLE, configure=1 latches the configuration and enters RUN, unless num_iters==0 or num_reads_per_iter==0; then it stays IDLE and emits nothing.
  - configure is ignored in RUN.
- RUN issues one read per cycle, back-to-back, with all strobes registered:
  - iteration k, beat r: act_read all ones; every act_addr = read_address+r.
  - weight_read=1; weight_addr = {k,r} concatenation truncated to LOG_MAX_ADDRESS.
- After the final beat (k=num_iters-1, r=num_reads_per_iter-1) strobes drop and the FSM returns to IDLE.
- Accumulation happens on a beat when weight_valid and all act_valid are 1.
  - Lane l product per element e: act element (routed per conf_mode_in) times weight byte l.
  - Accumulator width: 2*DATA_WIDTH+LOG_MAX_READS_PER_ITER.
  - Beat 0 of an iteration loads the product; later beats add it.
- Iteration end (valid beat count == num_reads_per_iter):
  - mode_out 0: sum all lane accumulators per element.
  - mode_out 1: use lane i for output i.
  - Clip: value<min_clip gives min_clip; value>max_clip gives max_clip; otherwise the low DATA_WIDTH bits.
  - Register the result; for one cycle valid_out = all ones, addr_out = write_address+k on every port.
- valid_out rises exactly 2 cycles after the cycle carrying the iteration's last read strobe. Consecutive iterations produce valid pulses num_reads_per_iter cycles apart.
- A latched min_clip>max_clip makes max_clip take precedence.
- Reset asserted mid-run aborts immediately: no further strobes or writes.

Decomposition:
- Package rtl_inf_pkg: FSM state enum {IDLE, RUN}; default parameter constants; accumulator-width function.
- One sub-module rtl_inf_lane: GROUP_SIZE parallel MACs with load/accumulate control and accumulator output.
- Top holds FSM, counters, input/output distribution, summation, clipping, output registers.

Test Plan:
- mode_in=1, mode_out=1, iters=2, reads=4, all act elements 1, all weight bytes 2 -> two valid_out pulses with every element 8, addr_out write_address then write_address+1; pulses 4 cycles apart.
- mode_in=0, mode_out=0, iters=4, reads=16, input0 elements 1, weights 1, max_clip=255 -> per-lane 16, lane sum 144, every output element 144, addresses write_address..+3.
- Same as previous with max_clip=100 -> elements 100; with min_clip=200, max_clip=255 -> elements 200.
- num_iters=0 with configure=1 -> no strobes, valid_out stays 0; second configure while RUN -> ignored, pulse count unchanged.
- Reset asserted mid-run -> all outputs 0 next cycle, no subsequent valid_out; a fresh configure afterwards produces correct results.
- read_address=4094, reads=4 -> act_addr sequence 4094, 4095, 0, 1 (wrap).
